// File: rtl/gate_pulse_decoder.sv
// Recovers a single-cycle trigger pulse from an asynchronous gate level and
// measures the gate high-time in sys_clk cycles, flagging short and long gates.
module gate_pulse_decoder #(
  parameter int MIN_WIDTH = 3,
  parameter int MAX_WIDTH = 15,
  parameter int HOLDOFF   = 2,
  parameter int CNT_W     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             gate_in,
  output logic             en_pulse,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             err_short,
  output logic             err_long,
  output logic             busy
);

  localparam int HOLD_LAST_I = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;

  localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_W     = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    HOLD     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_cnt;

  // s1/s2 form the metastability synchronizer; s3 only serves edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= gate_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Strobes (en_pulse, width_valid, err_short, err_long) are one-cycle valids
  // with no ready: a consumer must capture width in the cycle width_valid is high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      en_pulse    <= 1'b0;
      width       <= '0;
      width_valid <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      en_pulse    <= 1'b0;
      width_valid <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state    <= MEASURE;
            cnt      <= CNT_ONE;
            en_pulse <= 1'b1;
            busy     <= 1'b1;
          end
        end
        MEASURE: begin
          if (s2) begin
            if (cnt == MAX_W) begin
              err_long <= 1'b1;
              state    <= WAIT_LOW;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            width       <= cnt;
            width_valid <= 1'b1;
            err_short   <= (cnt < MIN_W);
            hold_cnt    <= '0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + CNT_ONE;
          // A gate already high again when holdoff ends must not retrigger.
          if (hold_cnt == HOLD_LAST) begin
            if (s2) begin
              state <= WAIT_LOW;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        WAIT_LOW: begin
          if (!s2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_pulse_decoder.sv
// Directed bench for gate_pulse_decoder: cycle-exact checks on pulse, width and
// error strobes, with a negedge monitor counting strobes and checking exclusivity.
module tb_gate_pulse_decoder;

  localparam int CNT_W = 8;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             gate_in;
  logic             en_pulse;
  logic [CNT_W-1:0] width;
  logic             width_valid;
  logic             err_short;
  logic             err_long;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;
  int n_valid = 0;
  int n_long = 0;
  int n_short = 0;
  int last_width = 0;
  int p0, v0, l0, sh0;

  gate_pulse_decoder #(
    .MIN_WIDTH(3),
    .MAX_WIDTH(15),
    .HOLDOFF(2),
    .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .gate_in(gate_in),
    .en_pulse(en_pulse),
    .width(width),
    .width_valid(width_valid),
    .err_short(err_short),
    .err_long(err_long),
    .busy(busy)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic en, input logic wv,
                           input logic [CNT_W-1:0] w, input logic es,
                           input logic el, input logic b);
    check({tag, "_en_pulse"}, {31'd0, en_pulse}, {31'd0, en});
    check({tag, "_width_valid"}, {31'd0, width_valid}, {31'd0, wv});
    check({tag, "_width"}, {24'd0, width}, {24'd0, w});
    check({tag, "_err_short"}, {31'd0, err_short}, {31'd0, es});
    check({tag, "_err_long"}, {31'd0, err_long}, {31'd0, el});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
  endtask

  // driver: gate high for w sampled cycles, then low
  task automatic pulse_gate(input int w);
    gate_in = 1'b1;
    repeat (w) tick();
    gate_in = 1'b0;
  endtask

  // after a clean fall: width_valid lands 3 cycles later, idle 2 cycles after that
  task automatic expect_valid(input string tag, input int w, input logic es);
    tick();
    tick();
    check({tag, "_pre_valid"}, {31'd0, width_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, width_valid}, 32'd1);
    check({tag, "_width"}, {24'd0, width}, w);
    check({tag, "_err_short"}, {31'd0, err_short}, {31'd0, es});
    check({tag, "_err_long"}, {31'd0, err_long}, 32'd0);
    tick();
    check({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic snapshot();
    p0 = n_pulse;
    v0 = n_valid;
    l0 = n_long;
    sh0 = n_short;
  endtask

  task automatic check_deltas(input string tag, input int dp, input int dv,
                              input int dl, input int ds);
    check({tag, "_n_pulse"}, n_pulse - p0, dp);
    check({tag, "_n_valid"}, n_valid - v0, dv);
    check({tag, "_n_long"}, n_long - l0, dl);
    check({tag, "_n_short"}, n_short - sh0, ds);
  endtask

  // scoreboard monitor: strobe counts and exclusivity rules
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (en_pulse) n_pulse++;
      if (width_valid) begin
        n_valid++;
        last_width = int'(width);
      end
      if (err_long) n_long++;
      if (err_short) n_short++;
      check("pulse_with_valid", {31'd0, en_pulse & width_valid}, 32'd0);
      check("long_with_valid", {31'd0, err_long & width_valid}, 32'd0);
      check("short_without_valid", {31'd0, err_short & ~width_valid}, 32'd0);
    end
  end

  initial begin
    gate_in   = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) tick();
    check_all("reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    repeat (2) tick();
    check_all("post_release", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // 6-cycle gate, cycle-exact
    snapshot();
    gate_in = 1'b1;
    tick();
    tick();
    check_all("g6_before_pulse", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("g6_pulse", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_all("g6_after_pulse", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    gate_in = 1'b0;
    expect_valid("g6", 6, 1'b0);
    check_deltas("g6", 1, 1, 0, 0);

    // short 2-cycle gate
    snapshot();
    pulse_gate(2);
    expect_valid("g2", 2, 1'b1);
    check_deltas("g2", 1, 1, 0, 1);

    // gate held high for 40 cycles
    snapshot();
    gate_in = 1'b1;
    repeat (17) tick();
    check({"long_pre_err"}, {31'd0, err_long}, 32'd0);
    tick();
    check_all("long_err", 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b1);
    tick();
    check({"long_err_one_cycle"}, {31'd0, err_long}, 32'd0);
    repeat (21) tick();
    check({"long_still_busy"}, {31'd0, busy}, 32'd1);
    gate_in = 1'b0;
    repeat (3) tick();
    check({"long_idle"}, {31'd0, busy}, 32'd0);
    check_deltas("long", 1, 0, 1, 0);
    snapshot();
    pulse_gate(6);
    expect_valid("after_long", 6, 1'b0);
    check_deltas("after_long", 1, 1, 0, 0);

    // re-rise inside holdoff must not retrigger
    snapshot();
    gate_in = 1'b1;
    repeat (6) tick();
    gate_in = 1'b0;
    tick();
    gate_in = 1'b1;
    repeat (8) tick();
    gate_in = 1'b0;
    repeat (5) tick();
    check({"rehigh_idle"}, {31'd0, busy}, 32'd0);
    check({"rehigh_width"}, last_width, 32'd6);
    check_deltas("rehigh", 1, 1, 0, 0);
    snapshot();
    pulse_gate(6);
    expect_valid("rehigh_next", 6, 1'b0);
    check_deltas("rehigh_next", 1, 1, 0, 0);

    // back-to-back gates 5, 3, 15, 16 with 6-cycle gaps
    snapshot();
    pulse_gate(5);
    expect_valid("b2b_5", 5, 1'b0);
    tick();
    pulse_gate(3);
    expect_valid("b2b_3", 3, 1'b0);
    tick();
    pulse_gate(15);
    expect_valid("b2b_15", 15, 1'b0);
    tick();
    pulse_gate(16);
    tick();
    tick();
    check_all("b2b_16_err", 1'b0, 1'b0, 8'd15, 1'b0, 1'b1, 1'b1);
    tick();
    check({"b2b_16_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) tick();
    check_deltas("b2b", 4, 3, 1, 0);

    // asynchronous reset in the middle of a 10-cycle gate
    gate_in = 1'b1;
    repeat (5) tick();
    check({"rst_mid_busy"}, {31'd0, busy}, 32'd1);
    sys_rst_n = 1'b0;
    #2;
    check_all("rst_async", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    snapshot();
    sys_rst_n = 1'b1;
    tick();
    check_all("rst_rel_1", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("rst_rel_2", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("rst_rel_pulse", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    gate_in = 1'b0;
    expect_valid("rst_rel", 3, 1'b0);
    check_deltas("rst_rel", 1, 1, 0, 0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
